// File: rtl/enet_pkg.sv
// Shared definitions for the enet receive scheduler: bus window offsets,
// status/control bit positions and the interrupt FSM state encoding.
package enet_pkg;

  // Word offsets inside the enet chip-select window
  localparam logic [1:0] ENET_DATA = 2'd0;
  localparam logic [1:0] ENET_STAT = 2'd1;
  localparam logic [1:0] ENET_CTRL = 2'd2;

  // Status word bit positions ([7:0] holds the FIFO count)
  localparam int unsigned STAT_EMPTY_BIT  = 8;
  localparam int unsigned STAT_FULL_BIT   = 9;
  localparam int unsigned STAT_OVF_BIT    = 10;
  localparam int unsigned STAT_INTR_BIT   = 11;
  localparam int unsigned STAT_OVFCNT_LSB = 16;

  // Control word bit positions
  localparam int unsigned CTRL_IRQ_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_OVF_BIT = 1;
  localparam int unsigned CTRL_FLUSH_BIT   = 2;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PEND    = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/enet_rx_fifo.sv
// DEPTH x 32 receive FIFO: synchronous write, asynchronous (combinational) read.
// Ports: push/wdata write a word (accepted when not full, or when a pop
// coincides), pop retires the head word, flush empties the FIFO and discards
// any same-cycle push. rdata is the head word; count/full/empty report occupancy.
module enet_rx_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & ~flush & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push & ~do_pop)      count_d = count_q + (AW+1)'(1);
      else if (do_pop & ~do_push) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/enet_rx_sched.sv
// Ethernet receive scheduler between the RMII receiver and the CPU54 bus.
// Ports: rx_ack/rx_data deliver words (rising edge of rx_ack = new word);
// cs/rd/wr/addr_sel/wdata form the bus window (0 data, 1 status, 2 control);
// rdata is the combinational read mux; intr/inta are the CPU interrupt
// handshake. Words queue in a FIFO; an FSM schedules intr with a threshold,
// service tracking and a post-service hold-off.
module enet_rx_sched
  import enet_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned THRESH  = 1,
  parameter int unsigned HOLDOFF = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ack,
  input  logic [31:0] rx_data,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  addr_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        intr,
  input  logic        inta
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic          rx_ack_q;
  logic          ovf_q, ovf_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;
  logic          irq_en_q, irq_en_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          intr_q, intr_d;
  irq_state_e    state_q, state_d;

  logic          push, pop, flush, ctrl_wr, drop, over_thresh;
  logic [31:0]   head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:3];

  enet_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (rx_data),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    push        = rx_ack & ~rx_ack_q;
    ctrl_wr     = cs & wr & (addr_sel == ENET_CTRL);
    flush       = ctrl_wr & wdata[CTRL_FLUSH_BIT];
    pop         = cs & rd & (addr_sel == ENET_DATA) & ~empty;
    // A flushed push is discarded silently, not counted as overflow
    drop        = push & full & ~pop & ~flush;
    over_thresh = (32'(count) >= THRESH);

    irq_en_d  = ctrl_wr ? wdata[CTRL_IRQ_EN_BIT] : irq_en_q;
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;
    if (ctrl_wr & wdata[CTRL_CLR_OVF_BIT]) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IRQ_IDLE: begin
        if (hold_q != '0) hold_d = hold_q - HW'(1);
        if (irq_en_q && (hold_q == '0) && over_thresh) state_d = IRQ_PEND;
      end
      IRQ_PEND: begin
        if (!irq_en_q) begin
          state_d = IRQ_IDLE;
        end else if (flush) begin
          state_d = IRQ_IDLE;
          hold_d  = HW'(HOLDOFF);
        end else if (inta | pop) begin
          state_d = IRQ_SERVICE;
        end
      end
      IRQ_SERVICE: begin
        if (!irq_en_q) begin
          state_d = IRQ_IDLE;
        end else if (empty | flush) begin
          state_d = IRQ_IDLE;
          hold_d  = HW'(HOLDOFF);
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
    intr_d = (state_d == IRQ_PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ack_q  <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
      irq_en_q  <= 1'b1;
      hold_q    <= '0;
      intr_q    <= 1'b0;
      state_q   <= IRQ_IDLE;
    end else begin
      rx_ack_q  <= rx_ack;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
      irq_en_q  <= irq_en_d;
      hold_q    <= hold_d;
      intr_q    <= intr_d;
      state_q   <= state_d;
    end
  end

  assign intr = intr_q;

  always_comb begin
    rdata = '0;
    unique case (addr_sel)
      ENET_DATA: rdata = empty ? '0 : head;
      ENET_STAT: begin
        rdata[7:0]                           = 8'(count);
        rdata[STAT_EMPTY_BIT]                = empty;
        rdata[STAT_FULL_BIT]                 = full;
        rdata[STAT_OVF_BIT]                  = ovf_q;
        rdata[STAT_INTR_BIT]                 = intr_q;
        rdata[STAT_OVFCNT_LSB +: 8]          = ovf_cnt_q;
      end
      ENET_CTRL: rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      default:   rdata = '0;
    endcase
  end

endmodule
